// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl
//   Stall/flush controller for the 5-stage RV32I pipeline. It covers the
//   hazards that forwarding cannot hide: load-use, branch-on-load (load in
//   E or M), taken-branch redirect and data-memory wait. It also keeps
//   saturating stall-cycle and flush counters.
// Ports
//   i_clk, i_reset         : clock and synchronous active-high reset
//   i_rs*_addr_D/_use_D    : source registers of the D instruction
//   i_is_br_D, i_br_taken_D: D is a branch/jalr, and it resolved taken
//   i_rd_addr_E/M, i_rd_wren_E/M, i_mem_rd_E/M : producers in E and M
//   i_lsu_busy             : data memory not ready, M cannot complete
//   o_stall_F/D/E/M        : hold PC and the pipeline registers
//   o_flush_D/E            : insert a bubble into IF/ID and ID/EX
//   o_stall_cnt            : cycles with o_stall_D=1, saturating
//   o_flush_cnt            : taken-branch flushes, saturating
module hazard_stall_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [4:0]       i_rs1_addr_D,
  input  logic [4:0]       i_rs2_addr_D,
  input  logic             i_rs1_use_D,
  input  logic             i_rs2_use_D,
  input  logic             i_is_br_D,
  input  logic             i_br_taken_D,
  input  logic [4:0]       i_rd_addr_E,
  input  logic             i_rd_wren_E,
  input  logic             i_mem_rd_E,
  input  logic [4:0]       i_rd_addr_M,
  input  logic             i_rd_wren_M,
  input  logic             i_mem_rd_M,
  input  logic             i_lsu_busy,
  output logic             o_stall_F,
  output logic             o_stall_D,
  output logic             o_stall_E,
  output logic             o_stall_M,
  output logic             o_flush_D,
  output logic             o_flush_E,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
);

  typedef enum logic {RUN, STALL} state_t;

  state_t state;
  // Extra stall cycles still owed after the current STALL cycle. The H2
  // window is exactly two cycles, so it is always loaded with 0.
  logic   stall_left;

  logic m_e, m_m, h1, h2, hz_cyc;

  // x0 is never a real producer, so a zero address can never match.
  assign m_e = i_rd_wren_E &&
               ((i_rs1_use_D && i_rs1_addr_D != 5'd0 && i_rs1_addr_D == i_rd_addr_E) ||
                (i_rs2_use_D && i_rs2_addr_D != 5'd0 && i_rs2_addr_D == i_rd_addr_E));
  assign m_m = i_rd_wren_M &&
               ((i_rs1_use_D && i_rs1_addr_D != 5'd0 && i_rs1_addr_D == i_rd_addr_M) ||
                (i_rs2_use_D && i_rs2_addr_D != 5'd0 && i_rs2_addr_D == i_rd_addr_M));

  // ALU producers are forwarded; only loads create hazards. A branch needs
  // its operands in D, so a load in M still costs it one cycle.
  assign h2 = i_is_br_D && i_mem_rd_E && m_e;
  assign h1 = (!i_is_br_D && i_mem_rd_E && m_e) || (i_is_br_D && i_mem_rd_M && m_m);

  assign hz_cyc = (state == STALL) || h1 || h2;

  always_comb begin
    o_stall_F = 1'b0;
    o_stall_D = 1'b0;
    o_stall_E = 1'b0;
    o_stall_M = 1'b0;
    o_flush_D = 1'b0;
    o_flush_E = 1'b0;
    if (!i_reset) begin
      if (i_lsu_busy) begin
        // Whole pipe freezes; nothing may be discarded while M waits.
        o_stall_F = 1'b1;
        o_stall_D = 1'b1;
        o_stall_E = 1'b1;
        o_stall_M = 1'b1;
      end else if (hz_cyc) begin
        // Hold F/D, bubble into E. A taken branch here is not yet valid
        // because its operands were stale, so no redirect.
        o_stall_F = 1'b1;
        o_stall_D = 1'b1;
        o_flush_E = 1'b1;
      end else if (i_br_taken_D) begin
        o_flush_D = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state       <= RUN;
      stall_left  <= 1'b0;
      o_stall_cnt <= '0;
      o_flush_cnt <= '0;
    end else begin
      if (!i_lsu_busy) begin
        case (state)
          RUN: if (h2) begin
            state      <= STALL;
            stall_left <= 1'b0;
          end
          STALL: begin
            if (stall_left) stall_left <= 1'b0;
            else            state      <= RUN;
          end
          default: state <= RUN;
        endcase
      end
      if (o_stall_D && o_stall_cnt != {CNT_W{1'b1}}) o_stall_cnt <= o_stall_cnt + 1'b1;
      if (o_flush_D && o_flush_cnt != {CNT_W{1'b1}}) o_flush_cnt <= o_flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: directed scenarios plus randomized traffic,
// all checked against a cycle-level model built from the hazard rules with
// a pending-stall countdown and saturating integer counters.
module tb_hazard_stall_ctrl;
  localparam int CW  = 4;
  localparam int MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [4:0] rs1, rs2, rd_e, rd_m;
  logic       use1, use2, is_br, taken, wr_e, ld_e, wr_m, ld_m, busy;
  logic       s_f, s_d, s_e, s_m, f_d, f_e;
  logic [CW-1:0] scnt, fcnt;

  hazard_stall_ctrl #(.CNT_W(CW)) dut (
    .i_clk(clk), .i_reset(reset),
    .i_rs1_addr_D(rs1), .i_rs2_addr_D(rs2), .i_rs1_use_D(use1), .i_rs2_use_D(use2),
    .i_is_br_D(is_br), .i_br_taken_D(taken),
    .i_rd_addr_E(rd_e), .i_rd_wren_E(wr_e), .i_mem_rd_E(ld_e),
    .i_rd_addr_M(rd_m), .i_rd_wren_M(wr_m), .i_mem_rd_M(ld_m),
    .i_lsu_busy(busy),
    .o_stall_F(s_f), .o_stall_D(s_d), .o_stall_E(s_e), .o_stall_M(s_m),
    .o_flush_D(f_d), .o_flush_E(f_e),
    .o_stall_cnt(scnt), .o_flush_cnt(fcnt)
  );

  int checks = 0, errors = 0;
  // model state
  int pend = 0, m_scnt = 0, m_fcnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit hit(bit u, logic [4:0] rs, logic [4:0] rd, bit w);
    return u && w && rs != 0 && rs == rd;
  endfunction

  task automatic clr();
    reset = 0; rs1 = 0; rs2 = 0; rd_e = 0; rd_m = 0;
    use1 = 0; use2 = 0; is_br = 0; taken = 0; wr_e = 0; ld_e = 0;
    wr_m = 0; ld_m = 0; busy = 0;
  endtask

  // Inputs are already applied; check this cycle, advance model, move on.
  task automatic step();
    bit me, mm, h1, h2;
    logic [5:0] e;  // {sF,sD,sE,sM,fD,fE}
    #1;
    me = hit(use1, rs1, rd_e, wr_e) || hit(use2, rs2, rd_e, wr_e);
    mm = hit(use1, rs1, rd_m, wr_m) || hit(use2, rs2, rd_m, wr_m);
    h2 = is_br && ld_e && me;
    h1 = (!is_br && ld_e && me) || (is_br && ld_m && mm);
    e = 6'b0;
    if (!reset) begin
      if (busy)                   e = 6'b111100;
      else if (pend > 0 || h1 || h2) e = 6'b110001;
      else if (taken)             e = 6'b000010;
    end
    chk("ctrl", {s_f, s_d, s_e, s_m, f_d, f_e}, {26'd0, e});
    chk("stall_cnt", {28'd0, scnt}, m_scnt);
    chk("flush_cnt", {28'd0, fcnt}, m_fcnt);
    if (reset) begin
      pend = 0; m_scnt = 0; m_fcnt = 0;
    end else begin
      if (e[4] && m_scnt < MAX) m_scnt++;
      if (e[1] && m_fcnt < MAX) m_fcnt++;
      if (!busy) begin
        if (pend > 0) pend--;
        else if (h2)  pend = 1;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    clr(); reset = 1; step(); step(); reset = 0;
  endtask

  initial begin
    clr();
    @(negedge clk);
    do_reset();

    // load-use: lw x5 in E, add using x5
    ld_e = 1; wr_e = 1; rd_e = 5; use1 = 1; rs1 = 5; step();
    clr(); step();
    chk("loaduse_cnt", {28'd0, scnt}, 1);

    // branch on load in E: two stall cycles, then taken redirect
    do_reset();
    ld_e = 1; wr_e = 1; rd_e = 7; is_br = 1; use2 = 1; rs2 = 7; step();
    ld_e = 0; wr_e = 0; ld_m = 1; wr_m = 1; rd_m = 7; step();
    ld_m = 0; wr_m = 0; taken = 1; step();
    clr(); step();
    chk("h2_scnt", {28'd0, scnt}, 2);
    chk("h2_fcnt", {28'd0, fcnt}, 1);

    // ALU producer and x0 load: no stall
    do_reset();
    wr_e = 1; rd_e = 3; is_br = 1; use1 = 1; rs1 = 3; step();
    clr(); ld_e = 1; wr_e = 1; rd_e = 0; use1 = 1; rs1 = 0; step();
    clr(); step();
    chk("nohaz_cnt", {28'd0, scnt}, 0);

    // H2 interrupted by a 3-cycle memory wait
    do_reset();
    ld_e = 1; wr_e = 1; rd_e = 9; is_br = 1; use1 = 1; rs1 = 9; step();
    busy = 1; repeat (3) step();
    busy = 0; ld_e = 0; wr_e = 0; step();
    clr(); step();
    chk("busy_scnt", {28'd0, scnt}, 5);

    // taken together with branch-on-load-in-M: stall wins, no redirect
    do_reset();
    is_br = 1; taken = 1; use1 = 1; rs1 = 5; ld_m = 1; wr_m = 1; rd_m = 5; step();
    clr(); step();
    chk("br_h1_fcnt", {28'd0, fcnt}, 0);

    // reset in STALL aborts it
    do_reset();
    ld_e = 1; wr_e = 1; rd_e = 4; is_br = 1; use1 = 1; rs1 = 4; step();
    clr(); reset = 1; step();
    reset = 0; step();

    // saturation
    do_reset();
    ld_e = 1; wr_e = 1; rd_e = 6; use2 = 1; rs2 = 6;
    repeat (MAX + 3) step();
    clr(); step();
    chk("sat_scnt", {28'd0, scnt}, MAX);

    // randomized traffic
    do_reset();
    repeat (4000) begin
      reset = ($urandom_range(0, 99) < 2);
      rs1   = 5'($urandom_range(0, 3)); rs2 = 5'($urandom_range(0, 3));
      rd_e  = 5'($urandom_range(0, 3)); rd_m = 5'($urandom_range(0, 3));
      use1  = 1'($urandom_range(0, 1)); use2 = 1'($urandom_range(0, 1));
      is_br = ($urandom_range(0, 9) < 4); taken = 1'($urandom_range(0, 1));
      wr_e  = ($urandom_range(0, 3) != 0); wr_m = ($urandom_range(0, 3) != 0);
      ld_e  = ($urandom_range(0, 9) < 4); ld_m = ($urandom_range(0, 9) < 4);
      busy  = ($urandom_range(0, 9) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Stall/flush controller for the 5-stage RV32I pipeline. It covers the hazards that the decode-stage branch forwarding and the EX forwarding network cannot resolve: load-use, branch-on-load, taken-branch redirect, and multi-cycle data-memory wait.
- Sits beside the D-stage forwarding logic. It consumes the same D/E/M register-address and write-enable signals and drives the per-stage enable and bubble controls.
- Also keeps a saturating stall-cycle performance counter.

Parameters:
CNT_W, 32, width of stall/flush performance counters.

Ports:
i_clk  input  1  clock, rising edge
i_reset  input  1  synchronous reset, active-high
i_rs1_addr_D  input  5  rs1 of instruction in D
i_rs2_addr_D  input  5  rs2 of instruction in D
i_rs1_use_D  input  1  D instruction reads rs1
i_rs2_use_D  input  1  D instruction reads rs2
i_is_br_D  input  1  D instruction is branch/jalr (operands needed in D)
i_br_taken_D  input  1  branch resolved taken in D
i_rd_addr_E  input  5  rd of instruction in E
i_rd_wren_E  input  1  E instruction writes rd
i_mem_rd_E  input  1  E instruction is a load
i_rd_addr_M  input  5  rd of instruction in M
i_rd_wren_M  input  1  M instruction writes rd
i_mem_rd_M  input  1  M instruction is a load
i_lsu_busy  input  1  data memory not ready; M cannot complete
o_stall_F  output  1  hold PC
o_stall_D  output  1  hold IF/ID register
o_stall_E  output  1  hold ID/EX register
o_stall_M  output  1  hold EX/MEM register
o_flush_D  output  1  bubble IF/ID
o_flush_E  output  1  bubble ID/EX
o_stall_cnt  output  CNT_W  cycles with o_stall_D=1, saturating
o_flush_cnt  output  CNT_W  taken-branch flushes, saturating

Behaviour:
- Match definitions (combinational). A match requires the address to be nonzero.
  - mE(rs) = use && rs!=0 && rs==i_rd_addr_E && i_rd_wren_E.
  - mM(rs) is the same test against M.
- Hazard definitions (each is the OR over rs1/rs2):
  - H2 (branch on load in E) = i_is_br_D && i_mem_rd_E && mE.
  - H1 (1-cycle hazard) has two sources:
    - (!i_is_br_D && i_mem_rd_E && mE): load-use.
    - (i_is_br_D && i_mem_rd_M && mM): branch on load in M.
  - An ALU result in E or M feeding D is not a hazard; it is forwarded.
- FSM states: RUN, STALL. Register stall_left, 1 bit.
- Priority 1, i_lsu_busy=1 in any state:
  - o_stall_F/D/E/M=1 and all flushes 0.
  - State, stall_left and o_flush_cnt hold. o_stall_cnt increments.
- Priority 2, RUN and (H2 or H1):
  - o_stall_F=o_stall_D=1 and o_flush_E=1. o_stall_E=o_stall_M=0.
  - H2: next state STALL, stall_left=0.
  - H1 only: stay RUN.
  - i_br_taken_D is ignored this cycle.
- STALL, not busy:
  - Same outputs as a hazard cycle.
  - Next state is RUN unconditionally, so H2 always produces exactly 2 stall cycles.
- Priority 3, RUN, no hazard, i_br_taken_D=1:
  - o_flush_D=1 for that cycle only. No stall.
  - o_flush_cnt increments.
- Otherwise all control outputs are 0.
- Control outputs are combinational from state and inputs: zero latency, same cycle as detection.
- Counters:
  - Both counters update on the clock edge.
  - Both saturate at all-ones and never wrap.
  - o_stall_cnt counts every cycle with o_stall_D=1.
- Reset:
  - i_reset=1 is sampled at the edge. The next state is RUN, stall_left=0 and both counters are 0.
  - While i_reset=1, all stall and flush outputs are forced to 0.
  - A reset during STALL or a busy wait aborts it; the first post-reset cycle evaluates fresh in RUN.
- rd=x0 never causes a stall, even when the producer is a load.

Test Plan:
- lw x5 in E (i_mem_rd_E=1, rd_E=5, wren_E=1), add in D with rs1=5, i_is_br_D=0 -> 1 cycle of o_stall_F=o_stall_D=o_flush_E=1; o_stall_cnt 0->1.
- lw x7 in E, beq rs2=7 in D -> 2 consecutive stall cycles (RUN->STALL->RUN); o_stall_cnt=2; then beq taken -> o_flush_D=1 one cycle, o_flush_cnt=1.
- add x3 in E (not load), beq rs1=3 in D -> no stall/flush; load rd=0 with rs1=0 in D -> no stall.
- H2 stall cycle 1, then i_lsu_busy=1 for 3 cycles -> all four stalls=1 for 3 cycles; STALL resumes after busy drops; total o_stall_cnt=5.
- i_br_taken_D=1 together with H1 -> no o_flush_D, stall only; o_flush_cnt unchanged.
- i_reset=1 while in STALL -> next cycle RUN, all outputs 0, counters 0; preload counter to all-ones minus 1, two stall cycles -> holds at all-ones.
